l1_two_way_cache: RTL and testbench
===================================

Name: l1_two_way_cache

Overview:
- 2-way set-associative, write-back, write-allocate L1 data cache.
- Sits directly downstream of a processor core stimulus block. Consumes that block's read/write/address/write_data and returns fetched_data to it.
- Upstream of a flat backing memory, reached over a req/ack handshake.
- One byte per line. Pseudo-LRU is a single bit per set.

Parameters:
- ADDR_W, 16, core/memory address width.
- DATA_W, 8, data width (one line = one word).
- INDEX_W, 4, set index width (2^INDEX_W sets); tag width = ADDR_W-INDEX_W.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- read  in  1  core read request level.
- write  in  1  core write request level; has priority if both are high.
- address  in  ADDR_W  core byte address.
- write_data  in  DATA_W  core store data.
- fetched_data  out  DATA_W  load result; valid while core_ready=1.
- core_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  refill data; valid with mem_ack.
- mem_ack  in  1  memory completion pulse.

Behaviour:
- Reset values (async, while rst_n=0):
  - Outputs: fetched_data=0, core_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All valid, dirty and LRU bits = 0. State = IDLE.
- Reset mid-operation aborts any transaction with no writeback. Cache contents are lost.
- All outputs are registered.
- Address split: index = address[INDEX_W-1:0], tag = address[ADDR_W-1:INDEX_W].
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - If read|write, latch op, address and write_data, then go to LOOKUP.
  - Inputs are ignored after acceptance until core_ready.
- LOOKUP: compare the latched tag against both ways of the set.
  - Read hit: fetched_data = way data.
  - Write hit: way data = write_data, dirty = 1.
  - Any hit: LRU = other way; go to RESPOND.
  - Miss, victim selection: the invalid way, way0 if both are invalid; else the way named by LRU.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. Hold until mem_ack.
  - mem_req drops the cycle after ack; then go to REFILL.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr=latched address. Wait for mem_ack.
  - On ack, install into the victim way: tag, valid=1, LRU = other way.
  - Read: data = mem_rdata, dirty = 0, fetched_data = mem_rdata.
  - Write: data = write_data (refill data discarded), dirty = 1.
  - Go to RESPOND.
- RESPOND: core_ready=1 for exactly one cycle, then IDLE.
- Latency, counted from the acceptance edge:
  - Hit: core_ready in the 2nd cycle after acceptance.
  - Clean miss: 2 + refill wait.
  - Dirty miss: adds writeback wait.
- Core contract: drop or change the request in the cycle after core_ready. A held request is re-accepted as a new access.
- mem_ack while mem_req=0 is ignored. Memory may take unbounded cycles; no timeout.
- fetched_data holds its last value when not ready. It is not updated on writes.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments once per accepted access at LOOKUP resolution.
  - Saturate at 16'hFFFF. Reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package l1_cache_pkg:
  - FSM state enum.
  - Localparams TAG_W, SETS.
  - Way-entry struct {valid, dirty, tag, data}.
- Sub-module l1_way_array, instantiated twice:
  - Per-way storage, SETS entries.
  - Async read by index; synchronous write port with valid/dirty/tag/data enables.
  - Valid/dirty clear on rst_n.
- LRU bits and FSM live in the top.

Test Plan:
- Cold read:
  - Read 0x0012, memory returns 0x5A after 3 cycles.
  - Expect mem_req=1, mem_we=0, mem_addr=0x0012; core_ready pulse with fetched_data=0x5A.
  - No writeback.
- Read hit: repeat read 0x0012 -> core_ready on the 2nd cycle after acceptance, data 0x5A, mem_req stays 0.
- Write hit and dirty writeback:
  - Write 0xA5 to 0x0012 -> no memory traffic.
  - Then miss 0x0022 (same set, fills way1), then miss 0x0032.
  - Expect writeback with mem_we=1, mem_addr=0x0012, mem_wdata=0xA5 before the refill of 0x0032.
- LRU:
  - Fill 0x0003 and 0x0013, read hit 0x0003, then miss 0x0023.
  - Expect way holding 0x0013 evicted; a subsequent read of 0x0003 hits.
- Write miss (write-allocate):
  - Write 0x77 to 0x0100 -> refill read of 0x0100; then read 0x0100 hits with 0x77.
- Reset mid-REFILL:
  - Pull rst_n low while mem_req=1 -> mem_req=0 and core_ready=0 immediately.
  - After release, read 0x0012 misses.
  - With L1_CACHE_STATS_EN: counters read 0 after reset.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and sizing for the two-way L1 data cache: FSM states,
// geometry constants and the per-way entry record.
package l1_cache_pkg;

  localparam int L1_ADDR_W  = 16;
  localparam int L1_DATA_W  = 8;
  localparam int L1_INDEX_W = 4;
  localparam int TAG_W      = L1_ADDR_W - L1_INDEX_W;
  localparam int SETS       = 1 << L1_INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_W-1:0]     tag;
    logic [L1_DATA_W-1:0] data;
  } way_entry_t;

endpackage

// File: rtl/l1_way_array.sv
// Storage for one cache way: SETS entries, combinational read by index,
// synchronous write with independent field enables.
module l1_way_array
  import l1_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [L1_INDEX_W-1:0] idx_i,
  output way_entry_t            rd_entry_o,
  input  logic                  wr_valid_en_i,
  input  logic                  wr_dirty_en_i,
  input  logic                  wr_tag_en_i,
  input  logic                  wr_data_en_i,
  input  way_entry_t            wr_entry_i
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [L1_DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_valid_en_i) valid_q[idx_i] <= wr_entry_i.valid;
      if (wr_dirty_en_i) dirty_q[idx_i] <= wr_entry_i.dirty;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid gates every
  // use of them, so clearing valid alone empties the way and keeps them as plain RAM.
  always_ff @(posedge clk) begin
    if (wr_tag_en_i)  tag_q[idx_i]  <= wr_entry_i.tag;
    if (wr_data_en_i) data_q[idx_i] <= wr_entry_i.data;
  end

  always_comb begin
    rd_entry_o.valid = valid_q[idx_i];
    rd_entry_o.dirty = dirty_q[idx_i];
    rd_entry_o.tag   = tag_q[idx_i];
    rd_entry_o.data  = data_q[idx_i];
  end

endmodule

// File: rtl/l1_two_way_cache.sv
// Two-way set-associative write-back/write-allocate L1 data cache, one byte per line.
// Define L1_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_two_way_cache
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W  = L1_ADDR_W,
  parameter int DATA_W  = L1_DATA_W,
  parameter int INDEX_W = L1_INDEX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fetched_data,
  output logic              core_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TW    = ADDR_W - INDEX_W;
  localparam int NSETS = 1 << INDEX_W;

  state_e              state_q;
  logic                op_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                victim_q;
  logic [NSETS-1:0]    lru_q;
  logic [DATA_W-1:0]   fetched_data_q;
  logic                core_ready_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [INDEX_W-1:0]  idx;
  logic [TW-1:0]       tag;
  way_entry_t          ent0, ent1, victim_ent, wr_entry_d;
  logic                hit0, hit1, hit, victim_way, refill_done;
  logic [1:0]          valid_en_d, dirty_en_d, tag_en_d, data_en_d;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];

  l1_way_array u_way0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .idx_i         (idx),
    .rd_entry_o    (ent0),
    .wr_valid_en_i (valid_en_d[0]),
    .wr_dirty_en_i (dirty_en_d[0]),
    .wr_tag_en_i   (tag_en_d[0]),
    .wr_data_en_i  (data_en_d[0]),
    .wr_entry_i    (wr_entry_d)
  );

  l1_way_array u_way1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .idx_i         (idx),
    .rd_entry_o    (ent1),
    .wr_valid_en_i (valid_en_d[1]),
    .wr_dirty_en_i (dirty_en_d[1]),
    .wr_tag_en_i   (tag_en_d[1]),
    .wr_data_en_i  (data_en_d[1]),
    .wr_entry_i    (wr_entry_d)
  );

  assign hit0 = ent0.valid && (ent0.tag == tag);
  assign hit1 = ent1.valid && (ent1.tag == tag);
  assign hit  = hit0 || hit1;

  // An empty way is always preferred over evicting a live line.
  assign victim_way  = !ent0.valid ? 1'b0 : (!ent1.valid ? 1'b1 : lru_q[idx]);
  assign victim_ent  = victim_way ? ent1 : ent0;
  assign refill_done = (state_q == REFILL) && mem_req_q && mem_ack;

  // NOTE: every signal gets a default before the conditions below, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    valid_en_d       = '0;
    dirty_en_d       = '0;
    tag_en_d         = '0;
    data_en_d        = '0;
    wr_entry_d.valid = 1'b1;
    wr_entry_d.dirty = op_write_q;
    wr_entry_d.tag   = tag;
    wr_entry_d.data  = op_write_q ? wdata_q : mem_rdata;
    if ((state_q == LOOKUP) && hit && op_write_q) begin
      dirty_en_d[hit1] = 1'b1;
      data_en_d[hit1]  = 1'b1;
    end
    if (refill_done) begin
      valid_en_d[victim_q] = 1'b1;
      dirty_en_d[victim_q] = 1'b1;
      tag_en_d[victim_q]   = 1'b1;
      data_en_d[victim_q]  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_write_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      victim_q       <= 1'b0;
      lru_q          <= '0;
      fetched_data_q <= '0;
      core_ready_q   <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read || write) begin
            op_write_q <= write;
            addr_q     <= address;
            wdata_q    <= write_data;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!op_write_q) fetched_data_q <= hit1 ? ent1.data : ent0.data;
            lru_q[idx]   <= ~hit1;
            core_ready_q <= 1'b1;
            state_q      <= RESPOND;
          end else begin
            victim_q  <= victim_way;
            mem_req_q <= 1'b1;
            if (victim_ent.valid && victim_ent.dirty) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {victim_ent.tag, idx};
              mem_wdata_q <= victim_ent.data;
              state_q     <= WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= addr_q;
              state_q    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= REFILL;
          end
        end
        REFILL: begin
          // Arriving from writeback the request is low for one cycle; raise it here.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
          end else if (mem_ack) begin
            mem_req_q    <= 1'b0;
            lru_q[idx]   <= ~victim_q;
            if (!op_write_q) fetched_data_q <= mem_rdata;
            core_ready_q <= 1'b1;
            state_q      <= RESPOND;
          end
        end
        RESPOND: begin
          core_ready_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetched_data = fetched_data_q;
  assign core_ready   = core_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

`ifdef L1_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_two_way_cache.sv
// Directed bench for l1_two_way_cache: a vector table of core accesses with
// hand-computed results against a behavioural backing memory, plus a reset-abort sequence.
module tb_l1_two_way_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  write_data = '0;
  logic [7:0]  fetched_data;
  logic        core_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef L1_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l1_two_way_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read         (read),
    .write        (write),
    .address      (address),
    .write_data   (write_data),
    .fetched_data (fetched_data),
    .core_ready   (core_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Backing memory: default contents are (addr + 0x40) & 0xFF, with 0x0012 = 0x5A.
  logic [7:0]  mem [0:65535];
  int          mem_delay = 3;
  int          mcnt = 0;
  int          wb_cnt = 0, rf_cnt = 0, req_cnt = 0, rf_wb_at = 0;
  logic [15:0] wb_addr = '0, rf_addr = '0;
  logic [7:0]  wb_data = '0;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a + 8'h40);
    mem[16'h0012] = 8'h5A;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      req_cnt++;
      if (mcnt == mem_delay - 1) begin
        mcnt    = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wb_cnt++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr];
          rf_cnt++;
          rf_addr  = mem_addr;
          rf_wb_at = wb_cnt;
        end
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one access, drop the request after acceptance, return cycles to core_ready.
  task automatic do_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                           output int cyc);
    @(negedge clk);
    read = !wr; write = wr; address = a; write_data = d;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!core_ready && cyc < 200);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          hit;
    bit          wb;
    logic [15:0] wb_addr;
    logic [7:0]  wb_data;
    logic [7:0]  exp_data;
    int          cycles;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cyc, rf0, wb0, rq0, n_hit;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, rf0, wb0, rq0, n_hit;
    //          wr addr      wdata  hit wb  wb_addr    wb_data data   cyc
    vecs[0]  = '{0, 16'h0012, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h5A, 5}; // cold read
    vecs[1]  = '{0, 16'h0012, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h5A, 2}; // read hit
    vecs[2]  = '{1, 16'h0012, 8'hA5, 1, 0, 16'h0000, 8'h00, 8'h5A, 2}; // write hit, data held
    vecs[3]  = '{0, 16'h0022, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h62, 5}; // fills way1
    vecs[4]  = '{0, 16'h0032, 8'h00, 0, 1, 16'h0012, 8'hA5, 8'h72, 9}; // dirty eviction
    vecs[5]  = '{0, 16'h0003, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h43, 5};
    vecs[6]  = '{0, 16'h0013, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h53, 5};
    vecs[7]  = '{0, 16'h0003, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h43, 2};
    vecs[8]  = '{0, 16'h0023, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h63, 5}; // evicts 0x0013
    vecs[9]  = '{0, 16'h0003, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h43, 2}; // LRU kept it
    vecs[10] = '{0, 16'h0013, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h53, 5}; // was evicted
    vecs[11] = '{1, 16'h0100, 8'h77, 0, 0, 16'h0000, 8'h00, 8'h53, 5}; // write miss
    vecs[12] = '{0, 16'h0100, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h77, 2};
    vecs[13] = '{1, 16'h0200, 8'h11, 0, 0, 16'h0000, 8'h00, 8'h77, 5};
    vecs[14] = '{0, 16'h0300, 8'h00, 0, 1, 16'h0100, 8'h77, 8'h40, 9};
    vecs[15] = '{0, 16'h0200, 8'h00, 1, 0, 16'h0000, 8'h00, 8'h11, 2};

    #1;
    check("reset_outputs", {core_ready, mem_req, mem_we, mem_addr, mem_wdata, fetched_data}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    n_hit = 0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].hit) n_hit++;
      rf0 = rf_cnt; wb0 = wb_cnt; rq0 = req_cnt;
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc);
      check($sformatf("v%0d_ready", i), core_ready, 1);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
      check($sformatf("v%0d_data", i), fetched_data, vecs[i].exp_data);
      if (vecs[i].hit) begin
        check($sformatf("v%0d_no_mem", i), req_cnt - rq0, 0);
      end else begin
        check($sformatf("v%0d_refills", i), rf_cnt - rf0, 1);
        check($sformatf("v%0d_refill_addr", i), rf_addr, vecs[i].addr);
        check($sformatf("v%0d_writebacks", i), wb_cnt - wb0, vecs[i].wb ? 1 : 0);
        if (vecs[i].wb) begin
          check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].wb_addr);
          check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wb_data);
          check($sformatf("v%0d_wb_first", i), rf_wb_at, wb0 + 1);
        end
      end
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", i), core_ready, 0);
    end

`ifdef L1_CACHE_STATS_EN
    check("hit_count", hit_count, n_hit);
    check("miss_count", miss_count, 16 - n_hit);
`endif

    // Reset while a slow refill is outstanding.
    mem_delay = 40;
    @(negedge clk);
    read = 1'b1; address = 16'h0045;
    @(posedge clk);
    #1 read = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_req_raised", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_core_ready", core_ready, 0);
    check("abort_outputs", {mem_we, mem_addr, mem_wdata, fetched_data}, 64'h0);
`ifdef L1_CACHE_STATS_EN
    check("abort_counters", {hit_count, miss_count}, 64'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_delay = 3;

    // Previously cached line must now miss; 0x0012 returns its written-back value.
    rf0 = rf_cnt;
    do_access(1'b0, 16'h0022, 8'h00, cyc);
    check("post_rst_0022_refill", rf_cnt - rf0, 1);
    check("post_rst_0022_data", fetched_data, 8'h62);
    check("post_rst_0022_cycles", cyc, 5);
    rf0 = rf_cnt; wb0 = wb_cnt;
    do_access(1'b0, 16'h0012, 8'h00, cyc);
    check("post_rst_0012_refill", rf_cnt - rf0, 1);
    check("post_rst_0012_no_wb", wb_cnt - wb0, 0);
    check("post_rst_0012_data", fetched_data, 8'hA5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
